// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Two-requester (IFU read / LSU load-store) arbiter in front of a
//            single-port memory whose read data is valid combinationally in
//            the same cycle as the read strobe. Each transaction is
//            IDLE -> ACCESS -> RESP, one cycle per state.
// Config   : MEM_ARB_RR_EN defined   -> round-robin arbitration
//            MEM_ARB_RR_EN undefined -> fixed priority, LSU wins
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter (
   input  logic        clock,
   input  logic        reset,
   // instruction-fetch port (read only)
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [63:0] ifu_addr,
   output logic        ifu_resp_valid,
   output logic [63:0] ifu_rdata,
   // load/store port
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic        lsu_wen,
   input  logic [63:0] lsu_addr,
   input  logic [63:0] lsu_wdata,
   input  logic [7:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   output logic [63:0] lsu_rdata,
   // memory port
   output logic [63:0] mem_raddr,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_gnt_lsu;   // transaction owner: 1 = LSU, 0 = IFU
   logic        r_is_write;  // LSU store
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;
   logic [63:0] r_ifu_rdata;
   logic [63:0] r_lsu_rdata;

   logic        w_pick_lsu;
   logic        w_idle;
   logic        w_accept;

`ifdef MEM_ARB_RR_EN
   logic        r_last_lsu;  // last grant went to LSU

   // Round-robin: on contention the side not granted last wins
   always_comb begin
      w_pick_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
   end
`else
   // Fixed priority: any LSU request beats the IFU
   always_comb begin
      w_pick_lsu = lsu_req_valid;
   end
`endif

   // Ready only in IDLE outside reset, and only toward the winner
   always_comb begin
      w_idle        = (r_state == ST_IDLE) && !reset;
      lsu_req_ready = w_idle && w_pick_lsu;
      ifu_req_ready = w_idle && ifu_req_valid && !w_pick_lsu;
      w_accept      = (lsu_req_valid && lsu_req_ready) ||
                      (ifu_req_valid && ifu_req_ready);
   end

   // Next-state sequencing: each non-idle state lasts exactly one cycle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_next = ST_ACCESS;
         ST_ACCESS: w_state_next = ST_RESP;
         ST_RESP:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Memory strobes and response pulses decoded from state and latched request
   always_comb begin
      mem_raddr      = 64'd0;
      mem_waddr      = 64'd0;
      mem_wdata      = 64'd0;
      mem_wmask      = 8'd0;
      mem_read_en    = 1'b0;
      mem_write_en   = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      if (r_state == ST_ACCESS) begin
         mem_raddr    = r_addr;
         mem_waddr    = r_addr;
         mem_read_en  = !r_is_write;
         mem_write_en = r_is_write;
         if (r_is_write) begin
            mem_wdata = r_wdata;
            mem_wmask = r_wmask;
         end
      end
      if (r_state == ST_RESP) begin
         ifu_resp_valid = !r_gnt_lsu;
         lsu_resp_valid = r_gnt_lsu;
      end
      ifu_rdata = r_ifu_rdata;
      lsu_rdata = r_lsu_rdata;
   end

   // State register, request capture on accept, read data capture in ACCESS
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_gnt_lsu   <= 1'b0;
         r_is_write  <= 1'b0;
         r_addr      <= 64'd0;
         r_wdata     <= 64'd0;
         r_wmask     <= 8'd0;
         r_ifu_rdata <= 64'd0;
         r_lsu_rdata <= 64'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_gnt_lsu  <= w_pick_lsu;
            r_is_write <= w_pick_lsu && lsu_wen;
            r_addr     <= w_pick_lsu ? lsu_addr : ifu_addr;
            r_wdata    <= lsu_wdata;
            r_wmask    <= lsu_wmask;
         end
         if (r_state == ST_ACCESS) begin
            if (!r_gnt_lsu)
               r_ifu_rdata <= mem_rdata;
            else
               r_lsu_rdata <= r_is_write ? 64'd0 : mem_rdata;
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember who was granted last; starts as LSU so IFU wins first contention
   always_ff @(posedge clock) begin
      if (reset)
         r_last_lsu <= 1'b1;
      else if (w_accept)
         r_last_lsu <= w_pick_lsu;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Expectations
//            depend on MEM_ARB_RR_EN for the contention test.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [63:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask;
   logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        mem_read_en, mem_write_en;

   int checks = 0;
   int errors = 0;
   int n_ifu, n_lsu;
   logic [3:0] order;   // bit k = 1 when grant k went to LSU

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clock          (clk),
      .reset          (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_wen        (lsu_wen),
      .lsu_addr       (lsu_addr),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .mem_raddr      (mem_raddr),
      .mem_waddr      (mem_waddr),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_rdata      (mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = 64'd0;
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 64'd0;
      lsu_wdata = 64'd0; lsu_wmask = 8'd0; mem_rdata = 64'd0;
      step(); step();

      // reset state; request must not be accepted under reset
      ifu_req_valid = 1'b1;
      #1;
      chk("rst_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
      chk("rst_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
      chk("rst_strobes",   {62'd0, mem_read_en, mem_write_en}, 64'd0);
      chk("rst_resp",      {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      chk("rst_ifu_rdata", ifu_rdata, 64'd0);
      ifu_req_valid = 1'b0;
      step();
      rst = 1'b0;
      step();

      // IFU read
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
      #1;
      chk("ifu_ready_idle", {63'd0, ifu_req_ready}, 64'd1);
      chk("lsu_ready_idle", {63'd0, lsu_req_ready}, 64'd0);
      step();                                   // N+1: ACCESS
      mem_rdata = 64'h1122_3344_5566_7788;
      ifu_addr  = 64'hDEAD_0000_0000_0040;      // changed while busy, still valid
      #1;
      chk("ifu_read_en",   {63'd0, mem_read_en}, 64'd1);
      chk("ifu_write_en",  {63'd0, mem_write_en}, 64'd0);
      chk("ifu_raddr",     mem_raddr, 64'h8000_0000);
      chk("ifu_wdata0",    mem_wdata, 64'd0);
      chk("ifu_busy_rdy",  {63'd0, ifu_req_ready}, 64'd0);
      chk("ifu_early_rsp", {63'd0, ifu_resp_valid}, 64'd0);
      step();                                   // N+2: RESP
      mem_rdata = 64'hFFFF_0000_FFFF_0000;
      #1;
      chk("ifu_resp_valid", {63'd0, ifu_resp_valid}, 64'd1);
      chk("ifu_rdata",      ifu_rdata, 64'h1122_3344_5566_7788);
      chk("ifu_lsu_resp",   {63'd0, lsu_resp_valid}, 64'd0);
      chk("ifu_resp_rden",  {63'd0, mem_read_en}, 64'd0);
      chk("ifu_resp_rdy",   {63'd0, ifu_req_ready}, 64'd0);
      step();                                   // back in IDLE
      chk("ifu_pulse_end",  {63'd0, ifu_resp_valid}, 64'd0);
      chk("ifu_rdata_hold", ifu_rdata, 64'h1122_3344_5566_7788);
      chk("ifu_wait_rdy",   {63'd0, ifu_req_ready}, 64'd1);
      ifu_req_valid = 1'b0;                     // withdraw before acceptance
      step(); step(); step();
      chk("withdraw_rden",  {63'd0, mem_read_en}, 64'd0);
      chk("withdraw_resp",  {63'd0, ifu_resp_valid}, 64'd0);

      // LSU load
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h100;
      #1;
      chk("ld_ready", {63'd0, lsu_req_ready}, 64'd1);
      step();
      lsu_req_valid = 1'b0;
      mem_rdata = 64'hCAFE_F00D_0BAD_BEEF;
      #1;
      chk("ld_read_en", {63'd0, mem_read_en}, 64'd1);
      chk("ld_raddr",   mem_raddr, 64'h100);
      step();
      chk("ld_resp",    {63'd0, lsu_resp_valid}, 64'd1);
      chk("ld_rdata",   lsu_rdata, 64'hCAFE_F00D_0BAD_BEEF);
      chk("ld_ifu_rsp", {63'd0, ifu_resp_valid}, 64'd0);
      step();

      // LSU store
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_0010;
      lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
      #1;
      chk("st_ready", {63'd0, lsu_req_ready}, 64'd1);
      step();
      lsu_req_valid = 1'b0; lsu_wdata = 64'h1; lsu_wmask = 8'hF0; lsu_addr = 64'h0;
      #1;
      chk("st_write_en", {63'd0, mem_write_en}, 64'd1);
      chk("st_read_en",  {63'd0, mem_read_en}, 64'd0);
      chk("st_waddr",    mem_waddr, 64'h8000_0010);
      chk("st_raddr",    mem_raddr, 64'h8000_0010);
      chk("st_wdata",    mem_wdata, 64'hDEAD_BEEF);
      chk("st_wmask",    {56'd0, mem_wmask}, 64'h0F);
      step();
      chk("st_resp",      {63'd0, lsu_resp_valid}, 64'd1);
      chk("st_rdata0",    lsu_rdata, 64'd0);
      chk("st_write_off", {63'd0, mem_write_en}, 64'd0);
      chk("st_ifu_hold",  ifu_rdata, 64'h1122_3344_5566_7788);
      step();

      // contention: both valid for 12 cycles, last grant so far was LSU
      lsu_wen = 1'b0; lsu_addr = 64'h200; ifu_addr = 64'h300;
      mem_rdata = 64'h5A5A;
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      n_ifu = 0; n_lsu = 0; order = 4'd0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (ifu_req_ready && lsu_req_ready) begin
            checks++; errors++;
            $error("FAIL both_ready: observed 1 expected 0 at cycle %0d", i);
         end
         if (lsu_req_ready) begin
            if (n_ifu + n_lsu < 4) order[n_ifu + n_lsu] = 1'b1;
            n_lsu++;
         end else if (ifu_req_ready) begin
            n_ifu++;
         end
         @(posedge clk);
      end
      #1;
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
      chk("rr_ifu_grants", 64'(n_ifu), 64'd2);
      chk("rr_lsu_grants", 64'(n_lsu), 64'd2);
      chk("rr_order",      {60'd0, order}, 64'b1010);
`else
      chk("fp_ifu_grants", 64'(n_ifu), 64'd0);
      chk("fp_lsu_grants", 64'(n_lsu), 64'd4);
      chk("fp_order",      {60'd0, order}, 64'b1111);
`endif
      step(); step(); step();

      // reset during ACCESS of a store
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h400;
      lsu_wdata = 64'h77; lsu_wmask = 8'hFF;
      step();
      lsu_req_valid = 1'b0;
      #1;
      chk("abort_in_access", {63'd0, mem_write_en}, 64'd1);
      rst = 1'b1;
      step();
      chk("abort_write_en", {63'd0, mem_write_en}, 64'd0);
      chk("abort_resp",     {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      chk("abort_ifu_rd",   ifu_rdata, 64'd0);
      chk("abort_lsu_rd",   lsu_rdata, 64'd0);
      chk("abort_waddr",    mem_waddr, 64'd0);
      rst = 1'b0;
      step();
      chk("abort_no_resp",  {63'd0, lsu_resp_valid}, 64'd0);

      // normal request after reset
      ifu_req_valid = 1'b1; ifu_addr = 64'h500;
      #1;
      chk("post_rst_ready", {63'd0, ifu_req_ready}, 64'd1);
      step();
      ifu_req_valid = 1'b0;
      mem_rdata = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("post_rst_rden",  {63'd0, mem_read_en}, 64'd1);
      chk("post_rst_raddr", mem_raddr, 64'h500);
      step();
      chk("post_rst_resp",  {63'd0, ifu_resp_valid}, 64'd1);
      chk("post_rst_rdata", ifu_rdata, 64'h0123_4567_89AB_CDEF);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
